// File: rtl/pio_out_pkg.sv
// Shared register map, pulse FSM encoding and STATUS bit layout for the pulsed output PIO.
// Pure declarations: no latency, no backpressure.
package pio_out_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_LEN    = 2'd1;
    localparam logic [1:0] ADDR_TRIG   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pulse_state_t;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_CNT_LSB  = 16;

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse timer: holds the pulse mask for len clocks after a load; a load while busy restarts it.
// State visible the edge after load; always accepts a load (no backpressure).
module pio_pulse_timer
    import pio_out_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] mask_in,
    output logic             busy,
    output logic [LEN_W-1:0] cnt,
    output logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] mask_nxt,
    output logic             pulse_end
);

    pulse_state_t state;

    assign busy = (state == PULSE);

    // Natural expiry only; a retrigger on the last cycle keeps the pulse alive.
    assign pulse_end = (state == PULSE) && (cnt == LEN_W'(1)) && !load;

    always_comb begin
        mask_nxt = mask;
        if (load)
            mask_nxt = mask_in;
        else if (pulse_end)
            mask_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            mask  <= '0;
        end else if (load) begin
            state <= PULSE;
            cnt   <= len;
            mask  <= mask_in;
        end else if (state == PULSE) begin
            if (cnt == LEN_W'(1)) begin
                state <= IDLE;
                cnt   <= '0;
                mask  <= '0;
            end else begin
                cnt <= cnt - LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with a static level plus timed OR-mask pulses; PIO_OUT_PULSE_IRQ_EN adds done/irq.
// Zero wait-state writes, 1-cycle registered reads, out_port registered; never backpressures.
module pio_out_pulse
    import pio_out_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               LEN_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
`ifdef PIO_OUT_PULSE_IRQ_EN
    ,
    output logic             irq
`endif
);

    logic             wr, wr_data, wr_len, wr_trig, wr_status, load;
    logic [WIDTH-1:0] data_reg, data_nxt, mask, mask_nxt;
    logic [LEN_W-1:0] len_reg, cnt;
    logic             busy, pulse_end;
    logic [31:0]      rd_nxt;

    assign wr        = chipselect && !write_n;
    assign wr_data   = wr && (address == ADDR_DATA);
    assign wr_len    = wr && (address == ADDR_LEN);
    assign wr_trig   = wr && (address == ADDR_TRIG);
    assign wr_status = wr && (address == ADDR_STATUS);

    // Zero mask or zero length would be a no-op pulse, so it is dropped entirely.
    assign load     = wr_trig && (writedata[WIDTH-1:0] != '0) && (len_reg != '0);
    assign data_nxt = wr_data ? writedata[WIDTH-1:0] : data_reg;

    pio_pulse_timer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .len       (len_reg),
        .mask_in   (writedata[WIDTH-1:0]),
        .busy      (busy),
        .cnt       (cnt),
        .mask      (mask),
        .mask_nxt  (mask_nxt),
        .pulse_end (pulse_end)
    );

`ifdef PIO_OUT_PULSE_IRQ_EN
    logic done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            done <= 1'b0;
        else if (pulse_end)
            done <= 1'b1;
        else if (wr_status)
            done <= 1'b0;
    end

    assign irq = done;

    logic unused_bits;
    assign unused_bits = ^writedata;
`else
    logic unused_bits;
    assign unused_bits = ^{writedata, pulse_end, wr_status};
`endif

    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_DATA: rd_nxt[WIDTH-1:0] = data_reg;
            ADDR_LEN:  rd_nxt[LEN_W-1:0] = len_reg;
            ADDR_TRIG: rd_nxt[WIDTH-1:0] = mask;
            default: begin
                rd_nxt[STAT_BUSY_BIT] = busy;
`ifdef PIO_OUT_PULSE_IRQ_EN
                rd_nxt[STAT_DONE_BIT] = done;
`endif
                rd_nxt[STAT_CNT_LSB +: LEN_W] = cnt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
            len_reg  <= '0;
            out_port <= RESET_VALUE;
            readdata <= '0;
        end else begin
            data_reg <= data_nxt;
            if (wr_len)
                len_reg <= writedata[LEN_W-1:0];
            out_port <= data_nxt | mask_nxt;
            readdata <= rd_nxt;
        end
    end

endmodule
